// File: rtl/layer_seq_ctrl.sv
// Control sequencer for a single-MAC fully connected layer (y = W*x, W is M x N).
// Loads x over a slave handshake, sequences M dot products, hands each row out.
module layer_seq_ctrl #(
  parameter int unsigned M    = 13,
  parameter int unsigned N    = 16,
  parameter int unsigned AW_X = $clog2(N),
  parameter int unsigned AW_W = $clog2(M * N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic            m_ready,
  output logic            m_valid,
  output logic            wr_en_x,
  output logic [AW_X-1:0] addr_x,
  output logic [AW_W-1:0] addr_w,
  output logic            clear_acc,
  output logic            en_acc
);

  localparam int unsigned RW = (M > 1) ? $clog2(M) : 1;
  localparam logic [AW_X-1:0] KLast   = AW_X'(N - 1);
  localparam logic [RW-1:0]   RowLast = RW'(M - 1);
  localparam logic [AW_W-1:0] WLast   = AW_W'(M * N - 1);

  typedef enum logic [2:0] {StLoad, StClr, StMac, StDrain, StOut} state_e;

  state_e          state_q, state_d;
  logic [AW_X-1:0] k_q, k_d;
  logic [RW-1:0]   row_q, row_d;
  logic [AW_W-1:0] addr_w_q, addr_w_d;
  logic            en_acc_q;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    row_d     = row_q;
    addr_w_d  = addr_w_q;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    wr_en_x   = 1'b0;
    clear_acc = 1'b0;
    unique case (state_q)
      StLoad: begin
        s_ready = 1'b1;
        wr_en_x = s_valid;
        if (s_valid) begin
          if (k_q == KLast) begin
            k_d     = '0;
            row_d   = '0;
            state_d = StClr;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      StClr: begin
        clear_acc = 1'b1;
        state_d   = StMac;
      end
      StMac: begin
        // Running weight address replaces row*N+k; wraps once per vector.
        addr_w_d = (addr_w_q == WLast) ? '0 : addr_w_q + 1'b1;
        if (k_q == KLast) begin
          k_d     = '0;
          state_d = StDrain;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDrain: begin
        state_d = StOut;
      end
      StOut: begin
        m_valid = 1'b1;
        if (m_ready) begin
          if (row_q == RowLast) begin
            row_d   = '0;
            state_d = StLoad;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = StClr;
          end
        end
      end
      default: begin
        state_d = StLoad;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StLoad;
      k_q      <= '0;
      row_q    <= '0;
      addr_w_q <= '0;
      en_acc_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      row_q    <= row_d;
      addr_w_q <= addr_w_d;
      // Memory read data lags the address by one cycle.
      en_acc_q <= (state_q == StMac);
    end
  end

  assign addr_x = k_q;
  assign addr_w = addr_w_q;
  assign en_acc = en_acc_q;

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Self-checking bench for layer_seq_ctrl: vector table for reset/load, scoreboard
// monitor for MAC addressing and results, directed stall and mid-MAC reset cases.
module tb_layer_seq_ctrl;

  localparam int M    = 13;
  localparam int N    = 16;
  localparam int AW_X = $clog2(N);
  localparam int AW_W = $clog2(M * N);

  logic            clk = 1'b0;
  logic            reset;
  logic            s_valid;
  logic            s_ready;
  logic            m_ready;
  logic            m_valid;
  logic            wr_en_x;
  logic [AW_X-1:0] addr_x;
  logic [AW_W-1:0] addr_w;
  logic            clear_acc;
  logic            en_acc;

  layer_seq_ctrl #(
    .M   (M),
    .N   (N),
    .AW_X(AW_X),
    .AW_W(AW_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .m_ready  (m_ready),
    .m_valid  (m_valid),
    .wr_en_x  (wr_en_x),
    .addr_x   (addr_x),
    .addr_w   (addr_w),
    .clear_acc(clear_acc),
    .en_acc   (en_acc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard: expected MAC weight addresses and per-row results, pushed at load time.
  int mac_q[$];
  int res_q[$];
  bit mon_en = 1'b0;

  task automatic push_vector();
    for (int r = 0; r < M; r++) begin
      res_q.push_back(r);
      for (int j = 0; j < N; j++) mac_q.push_back(r * N + j);
    end
  endtask

  int mac_left = 0;
  int en_cnt   = 0;
  int clr_cyc  = 0;
  int hs_cnt   = 0;
  bit mv_prev  = 1'b0;

  always @(negedge clk) begin
    int exp_w;
    int r;
    if (!mon_en) begin
      mac_left = 0;
      en_cnt   = 0;
      mv_prev  = 1'b0;
    end else begin
      if (clear_acc) begin
        mac_left = N;
        en_cnt   = 0;
        clr_cyc  = cyc;
      end else if (mac_left > 0) begin
        check(mac_q.size() > 0, "mac_queue_underflow", mac_q.size(), 1);
        if (mac_q.size() > 0) begin
          exp_w = mac_q.pop_front();
          check(int'(addr_w) == exp_w, "mac_addr_w", addr_w, exp_w);
          check(int'(addr_x) == exp_w % N, "mac_addr_x", addr_x, exp_w % N);
        end
        mac_left--;
      end
      if (en_acc) en_cnt++;
      if (m_valid && !mv_prev) check(cyc - clr_cyc == N + 2, "clr_to_mvalid", cyc - clr_cyc, N + 2);
      if (m_valid && m_ready) begin
        hs_cnt++;
        check(res_q.size() > 0, "extra_result", res_q.size(), 1);
        if (res_q.size() > 0) begin
          r = res_q.pop_front();
          check(en_cnt == N, "en_acc_count", en_cnt, N);
        end
      end
      mv_prev = m_valid;
    end
  end

  typedef struct {
    logic rst;
    logic sv;
    logic chk;
    logic sr;
    logic mv;
    logic wr;
    logic clr;
    logic en;
    int   ax;
    int   aw;
  } vec_t;

  vec_t tbl[21];

  task automatic load_full(output int e0v);
    e0v = 0;
    push_vector();
    s_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      e0v = cyc;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
  endtask

  // Runs until s_ready returns; optionally checks exact handshake timing from e0v.
  task automatic drain_vector(input string tag, input int e0v, input bit timed);
    int nh   = 0;
    bit seen = 1'b0;
    for (int t = 0; t < 2000 && !seen; t++) begin
      @(negedge clk);
      if (s_ready) begin
        seen = 1'b1;
      end else begin
        if (timed && m_valid && m_ready) begin
          check(cyc == e0v + (N + 3) * (nh + 1), {tag, "_row_spacing"}, cyc - e0v,
                (N + 3) * (nh + 1));
          nh++;
        end
        @(posedge clk);
        #1;
      end
    end
    check(seen, {tag, "_sready_timeout"}, seen, 1);
    if (timed) begin
      check(cyc == e0v + M * (N + 3) + 1, {tag, "_sready_return"}, cyc - e0v, M * (N + 3) + 1);
      check(nh == M, {tag, "_result_count"}, nh, M);
    end
    check(res_q.size() == 0, {tag, "_results_missing"}, res_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  e0;
    int  base;
    int  k;
    bit  seen;
    logic [20:0] got;
    logic [20:0] want;

    reset   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;

    for (int i = 0; i < 21; i++) begin
      tbl[i].rst = 1'b1; tbl[i].sv = 1'b0; tbl[i].chk = 1'b1;
      tbl[i].sr  = 1'b0; tbl[i].mv = 1'b0; tbl[i].wr  = 1'b0;
      tbl[i].clr = 1'b0; tbl[i].en = 1'b0; tbl[i].ax  = 0; tbl[i].aw = 0;
    end
    tbl[0].rst = 1'b0;
    tbl[0].chk = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tbl[i].sv = 1'b1; tbl[i].sr = 1'b1; tbl[i].wr = 1'b1; tbl[i].ax = i - 1;
    end
    tbl[17].clr = 1'b1;
    tbl[19].en = 1'b1; tbl[19].ax = 1; tbl[19].aw = 1;
    tbl[20].en = 1'b1; tbl[20].ax = 2; tbl[20].aw = 2;

    // Vector 1: reset, full-rate load, first MAC cycles, then timed drain.
    push_vector();
    e0 = 0;
    for (int i = 0; i < 21; i++) begin
      reset   = tbl[i].rst;
      s_valid = tbl[i].sv;
      if (i == 1) mon_en = 1'b1;
      @(negedge clk);
      if (i == 16) e0 = cyc;
      if (tbl[i].chk) begin
        got  = {s_ready, m_valid, wr_en_x, clear_acc, en_acc, 8'(addr_x), 8'(addr_w)};
        want = {tbl[i].sr, tbl[i].mv, tbl[i].wr, tbl[i].clr, tbl[i].en, 8'(tbl[i].ax),
                8'(tbl[i].aw)};
        check(got == want, "table", got, want);
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    drain_vector("v1", e0, 1'b1);

    // Vector 2: random s_valid gaps during load, then a 50-cycle stall on row 3.
    push_vector();
    k = 0;
    for (int t = 0; t < 300 && k < N; t++) begin
      s_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check(wr_en_x == s_valid && int'(addr_x) == k && s_ready, "rand_load",
            {s_ready, wr_en_x, 8'(addr_x)}, {1'b1, s_valid, 8'(k)});
      if (s_valid) k++;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    check(k == N, "rand_load_count", k, N);

    base = hs_cnt;
    for (int t = 0; t < 300 && hs_cnt - base < 3; t++) begin
      @(posedge clk);
      #1;
    end
    m_ready = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 60 && !seen; t++) begin
      @(negedge clk);
      if (m_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check(seen, "stall_reach_out", seen, 1);
    for (int i = 0; i < 50; i++) begin
      if (i > 0) @(negedge clk);
      check(m_valid && !clear_acc && !en_acc && !s_ready, "stall_hold",
            {m_valid, clear_acc, en_acc, s_ready}, 4'b1000);
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    @(negedge clk);
    check(m_valid, "stall_release_valid", m_valid, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check(clear_acc, "clr_after_release", clear_acc, 1);
    @(posedge clk);
    #1;
    drain_vector("v2", 0, 1'b0);

    // Vector 3: reset pulse in the middle of row 5's MAC phase.
    load_full(e0);
    base = hs_cnt;
    for (int t = 0; t < 300 && hs_cnt - base < 5; t++) begin
      @(posedge clk);
      #1;
    end
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      if (clear_acc) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    check(seen, "row5_clear_seen", seen, 1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    reset  = 1'b0;
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    mac_q.delete();
    res_q.delete();
    mon_en = 1'b1;
    @(negedge clk);
    got  = {s_ready, m_valid, wr_en_x, clear_acc, en_acc, 8'(addr_x), 8'(addr_w)};
    want = {5'b10000, 8'd0, 8'd0};
    check(got == want, "mid_mac_reset", got, want);
    @(posedge clk);
    #1;

    // Vector 4: full vector after the reset must yield all M results from row 0.
    base = hs_cnt;
    load_full(e0);
    drain_vector("v4", e0, 1'b1);
    check(hs_cnt - base == M, "v4_handshakes", hs_cnt - base, M);
    check(mac_q.size() == 0, "v4_mac_addr_left", mac_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
